pipe_add_sub: RTL
=================

# pipe_add_sub

Parametrised, pipelined two's-complement adder/subtractor. It is the next generation of the team's 4-bit ripple-carry adder. Operands of WIDTH bits are split into CHUNK-bit slices, and each slice is added in its own pipeline stage with the carry registered between stages. A valid/ready handshake on both sides carries backpressure, sustaining one operation per cycle. Carry-out, signed-overflow and zero flags are reported with every result.

## Interface
- WIDTH, default 16: operand and result width; must be a multiple of CHUNK and at least CHUNK.
- CHUNK, default 4: bits added per pipeline stage; STAGES = WIDTH/CHUNK.
- CLK  in  1  single clock; all state updates on the rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low; deassertion is synchronous to CLK.
- IN_VALID  in  1  an operation is presented on X/Y/C_IN/SUB.
- IN_READY  out  1  the pipeline accepts the operation in this cycle.
- X  in  WIDTH  operand A.
- Y  in  WIDTH  operand B.
- C_IN  in  1  carry-in; used only when SUB=0.
- SUB  in  1  0: SUM = X+Y+C_IN; 1: SUM = X−Y (X + ~Y + 1), C_IN ignored.
- OUT_VALID  out  1  result fields are valid.
- OUT_READY  in  1  the consumer takes the result in this cycle.
- SUM  out  WIDTH  result, modulo 2^WIDTH.
- C_OUT  out  1  carry out of bit WIDTH−1; for SUB=1, 1 means no borrow.
- OVF  out  1  signed overflow = carry into MSB XOR carry out of MSB.
- ZERO  out  1  SUM == 0.

## Operation
- Transfer rule: an input transfer occurs when IN_VALID && IN_READY; an output transfer occurs when OUT_VALID && OUT_READY.
- Stage 0 adds slice 0 of the inputs combinationally and registers the following:
  - SUM[CHUNK−1:0] and the carry;
  - the remaining upper bits of X and Y, with Y already inverted when SUB=1;
  - a valid bit.
- Stage k adds slice k to the carry from stage k−1 and appends the result bits. Lower result bits and not-yet-used operand bits shift forward unchanged (skew buffering).
- The last stage holds the full SUM, C_OUT, OVF and ZERO, and drives the outputs directly from registers.
- Backpressure:
  - ready_k = !valid_k || ready_(k+1).
  - ready of the last stage = !OUT_VALID || OUT_READY.
  - IN_READY = ready_0, a combinational chain with no bubble insertion.
- A stage whose valid bit is 0 holds its data unchanged; its data is don't-care but is never presented as valid.
- Ordering is strictly FIFO. No operation is dropped or duplicated.
- Reset values: OUT_VALID=0, SUM=0, C_OUT=0, OVF=0, ZERO=1. IN_READY is 1 during and immediately after reset, and all stage valid bits are 0.
- Reset asserted mid-operation: all in-flight operations are discarded immediately; no partial result is ever emitted.
- Degenerate case STAGES=1 (CHUNK=WIDTH): single registered adder with identical handshake.

## Timing
- Latency: an input transfer in cycle n gives OUT_VALID=1 in cycle n+STAGES when there is no stall.
- Throughput: one operation per cycle while OUT_READY=1.
- With OUT_READY held low, the pipeline absorbs exactly STAGES operations. IN_READY falls combinationally in the cycle after the STAGES-th acceptance.
- When OUT_READY and a full pipeline coincide, a new input is accepted in the same cycle the output is taken (simultaneous in/out).
- Outputs remain stable while OUT_VALID=1 and OUT_READY=0.
- Critical path: one CHUNK-bit ripple plus the ready chain (STAGES AND/OR levels).

## Structure
- Shared package dsd_arith_pkg holds:
  - the STAGES computation (WIDTH/CHUNK);
  - the parameter legality check (WIDTH % CHUNK == 0);
  - the mode encoding constants ADD=0, SUB=1.
- Sub-module add_slice: one CHUNK-bit ripple stage built from the team's existing full-adder cell. It outputs the slice sum, the carry out, and the carry into its top bit (used for OVF in the last slice).
- pipe_add_sub instantiates STAGES add_slice instances via generate, plus the stage registers and the handshake logic.

## Test plan
Defaults WIDTH=16, CHUNK=4.
- ADD, X=0xFFFF, Y=0x0001, C_IN=0 → SUM=0x0000, C_OUT=1, OVF=0, ZERO=1, with OUT_VALID 4 cycles after acceptance.
- ADD, X=0x7FFF, Y=0x0001, C_IN=0 → SUM=0x8000, C_OUT=0, OVF=1; and ADD, 0x1234+0x4321 with C_IN=1 → SUM=0x5556, C_OUT=0.
- SUB, X=0x0005, Y=0x0007 → SUM=0xFFFE, C_OUT=0, OVF=0; and SUB, X=0x8000, Y=0x0001 → SUM=0x7FFF, C_OUT=1, OVF=1.
- Stream 20 random operations with OUT_READY low for cycles 3–12:
  - exactly 4 operations are held;
  - IN_READY drops while stalled;
  - results match the reference model in order, with no loss or duplication.
- Back-to-back stream with OUT_READY=1 and IN_VALID=1 for 50 cycles → 50 results on consecutive cycles, and IN_READY never drops.
- Assert RST_N with 3 operations in flight → OUT_VALID drops immediately, SUM=0, ZERO=1. After deassertion, no stale result appears and the first new operation returns after 4 cycles.

Source files
------------

// File: rtl/dsd_arith_pkg.sv
// Shared arithmetic definitions for the pipelined adder family.
//   mode_e        : operation select, ADD (x + y + c_in) or SUB (x - y)
//   num_stages()  : number of pipeline stages for a WIDTH/CHUNK split
//   params_legal(): WIDTH must be a non-zero multiple of CHUNK
package dsd_arith_pkg;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } mode_e;

  function automatic int num_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic bit params_legal(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/pipe_add_sub_if.sv
// Request/response bus of the pipelined adder/subtractor.
//   Request : in_valid, in_ready, x, y, c_in, sub
//   Response: out_valid, out_ready, sum, c_out, ovf, zero
//   master  : the side that issues operations and consumes results
//   slave   : the arithmetic pipeline
interface pipe_add_sub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, x, y, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf, zero
  );

  modport slave (
    input  in_valid, x, y, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, ovf, zero
  );
endinterface

// File: rtl/add_slice.sv
// CHUNK-bit ripple-carry slice built from full_adder cells.
//   a, b, c_in : slice operands and carry in
//   sum        : slice sum
//   c_out      : carry out of the top bit
//   c_top      : carry into the top bit (signed overflow = c_top ^ c_out)
module add_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] sum,
  output logic             c_out,
  output logic             c_top
);
  // Each bit keeps its own carry nets so the ripple is a plain chain of
  // distinct signals rather than one vector feeding back into itself.
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    logic ci;
    logic co;
    if (i == 0) begin : g_lsb
      assign ci = c_in;
    end else begin : g_upper
      assign ci = g_bit[i-1].co;
    end
    full_adder u_fa (
      .a     (a[i]),
      .b     (b[i]),
      .c_in  (ci),
      .sum   (sum[i]),
      .c_out (co)
    );
  end

  assign c_out = g_bit[CHUNK-1].co;
  assign c_top = g_bit[CHUNK-1].ci;
endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
//   a, b, c_in : addend bits and carry in
//   sum, c_out : sum bit and carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined two's-complement adder/subtractor with valid/ready flow control.
// Stage k adds operand slice k; the carry, finished low result bits and the
// still-unused upper operand bits travel forward with the operation.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pipe_add_sub_if.slave (operation in, result + flags out)
module pipe_add_sub
  import dsd_arith_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  pipe_add_sub_if.slave bus
);
  localparam int STAGES = num_stages(WIDTH, CHUNK);

  if (!params_legal(WIDTH, CHUNK)) begin : g_param_check
    $error("pipe_add_sub: WIDTH must be a non-zero multiple of CHUNK");
  end

  // Stage registers
  logic [STAGES-1:0] vld;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  x_q   [STAGES];
  logic [WIDTH-1:0]  y_q   [STAGES];
  logic [STAGES-1:0] cy_q;
  logic              ovf_q;
  logic              zero_q;

  // Per-stage next values and handshake
  logic [STAGES-1:0] vin;
  logic [STAGES-1:0] rdy;
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  x_d   [STAGES];
  logic [WIDTH-1:0]  y_d   [STAGES];
  logic              co    [STAGES];
  logic              ctop  [STAGES];
  logic [WIDTH-1:0]  y_eff;
  logic              cin_eff;

  // Subtraction is x + ~y + 1; y is inverted once here and carried forward
  // already inverted, so later stages never look at the mode.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    y_eff   = bus.y;
    cin_eff = bus.c_in;
    if (mode_e'(bus.sub) == SUB) begin
      y_eff   = ~bus.y;
      cin_eff = 1'b1;
    end
  end

  // Stage k can load when it is empty or everything downstream can move.
  // Unrolling ready_k = !valid_k || ready_(k+1) gives "out_ready, or some
  // stage from k to the end is empty", computed here without a feedback net.
  always_comb begin
    logic all_full;
    all_full = 1'b1;
    rdy      = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      all_full = all_full & vld[k];
      rdy[k]   = bus.out_ready | ~all_full;
    end
  end

  always_comb begin
    vin    = vld << 1;
    vin[0] = bus.in_valid;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] a;
    logic [CHUNK-1:0] b;
    logic [CHUNK-1:0] s;
    logic             ci;

    if (k == 0) begin : g_first
      assign a        = bus.x[CHUNK-1:0];
      assign b        = y_eff[CHUNK-1:0];
      assign ci       = cin_eff;
      assign sum_d[k] = WIDTH'(s);
      assign x_d[k]   = bus.x;
      assign y_d[k]   = y_eff;
    end else begin : g_rest
      assign a        = x_q[k-1][k*CHUNK +: CHUNK];
      assign b        = y_q[k-1][k*CHUNK +: CHUNK];
      assign ci       = cy_q[k-1];
      // Keep the finished low slices, drop in this stage's slice above them.
      assign sum_d[k] = (sum_q[k-1] & ~({WIDTH{1'b1}} << (k*CHUNK)))
                      | (WIDTH'(s) << (k*CHUNK));
      assign x_d[k]   = x_q[k-1];
      assign y_d[k]   = y_q[k-1];
    end

    add_slice #(.CHUNK(CHUNK)) u_slice (
      .a     (a),
      .b     (b),
      .c_in  (ci),
      .sum   (s),
      .c_out (co[k]),
      .c_top (ctop[k])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the values its neighbours held before this clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the whole pipeline, datapath included, is reset: the last stage
      // drives the outputs directly and must show SUM=0/ZERO=1 after reset,
      // and the register array is small enough to clear in one go.
      vld    <= '0;
      cy_q   <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b1;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
        x_q[k]   <= '0;
        y_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          vld[k] <= vin[k];
          // An empty stage keeps its old data; only real operations load.
          if (vin[k]) begin
            sum_q[k] <= sum_d[k];
            x_q[k]   <= x_d[k];
            y_q[k]   <= y_d[k];
            cy_q[k]  <= co[k];
          end
        end
      end
      if (rdy[STAGES-1] && vin[STAGES-1]) begin
        ovf_q  <= co[STAGES-1] ^ ctop[STAGES-1];
        zero_q <= (sum_d[STAGES-1] == '0);
      end
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = vld[STAGES-1];
  assign bus.sum       = sum_q[STAGES-1];
  assign bus.c_out     = cy_q[STAGES-1];
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule
